// File: rtl/argmax_hex_display.sv
// Sequential argmax over NUM_CLASSES packed scores. The winner's index is shown on two
// active-low 7-segment digits, and an underscore is shown when the maximum is tied.
module argmax_hex_display #(
  parameter int NUM_CLASSES   = 10,
  parameter int SCORE_WIDTH   = 16,
  parameter bit SIGNED_SCORES = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CLASSES*SCORE_WIDTH-1:0] data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               done,
  output logic [7:0]                         class_idx,
  output logic [SCORE_WIDTH-1:0]             max_score,
  output logic                               tie,
  output logic [6:0]                         hex0,
  output logic [6:0]                         hex1
);

  localparam int CW = $clog2(NUM_CLASSES + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_UNDER = 7'h77;

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  state_t state_q, state_d;

  logic [NUM_CLASSES-1:0][SCORE_WIDTH-1:0] score_q;
  logic [CW-1:0]          cnt_q;
  logic [SCORE_WIDTH-1:0] run_max_q;
  logic [7:0]             run_idx_q;
  logic                   run_tie_q;
  logic [SCORE_WIDTH-1:0] cur;
  logic                   scan_last, gt, eq;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Inverting the sign bit maps two's complement onto an unsigned order.
  function automatic logic [SCORE_WIDTH-1:0] order_key(input logic [SCORE_WIDTH-1:0] v);
    order_key = SIGNED_SCORES ? {~v[SCORE_WIDTH-1], v[SCORE_WIDTH-2:0]} : v;
  endfunction

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (cnt_q == CW'(i)) cur = score_q[i];
  end

  assign scan_last = (cnt_q == CW'(NUM_CLASSES));
  assign gt        = order_key(cur) > order_key(run_max_q);
  assign eq        = (cur == run_max_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SCAN;
      SCAN:    if (scan_last) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    done     = (state_q == PUBLISH);
  end

  // The published registers load on the edge that enters PUBLISH, so they and done appear together.
  always_ff @(posedge clock) begin
    if (reset) begin
      score_q   <= '0;
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      run_tie_q <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      tie       <= 1'b0;
      hex0      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          score_q   <= data;
          run_max_q <= data[SCORE_WIDTH-1:0];
          run_idx_q <= '0;
          run_tie_q <= 1'b0;
          cnt_q     <= CW'(1);
        end
        SCAN: if (!scan_last) begin
          if (gt) begin
            run_max_q <= cur;
            run_idx_q <= 8'(cnt_q);
            run_tie_q <= 1'b0;
          end else if (eq) begin
            run_tie_q <= 1'b1;
          end
          cnt_q <= cnt_q + CW'(1);
        end else begin
          class_idx <= run_idx_q;
          max_score <= run_max_q;
          tie       <= run_tie_q;
          hex0      <= run_tie_q ? SEG_UNDER : seg7(run_idx_q[3:0]);
          hex1      <= (run_tie_q || NUM_CLASSES <= 16) ? SEG_BLANK : seg7(run_idx_q[7:4]);
        end
        default: ;
      endcase
    end
  end

endmodule
